// File: rtl/neuron_4input_driver_pkg.sv
// Shared constants and state encoding for the neuron operand driver.
package neuron_4input_driver_pkg;

   localparam int NUM_WORDS = 9;
   localparam int SLOT_X1   = 0;
   localparam int SLOT_W1   = 4;
   localparam int SLOT_B    = 8;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_FIRE = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   function automatic logic is_last_slot(input logic [3:0] idx);
      return idx == 4'(NUM_WORDS - 1);
   endfunction

endpackage

// File: rtl/neuron_4input_driver_if.sv
// Operand stream, result stream and neuron-facing bundle of the driver.
interface neuron_4input_driver_if #(
   parameter int WORD_W = 32
);
   import neuron_4input_driver_pkg::*;

   logic [WORD_W-1:0]   in_data;
   logic                in_valid;
   logic                in_ready;
   logic [WORD_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic [4*WORD_W-1:0] n_x;
   logic [4*WORD_W-1:0] n_w;
   logic [WORD_W-1:0]   n_b;
   logic                n_enable;
   logic [WORD_W-1:0]   n_f;

   modport master (
      input  in_data, in_valid, out_ready, n_f,
      output in_ready, out_data, out_valid, n_x, n_w, n_b, n_enable
   );

   modport slave (
      output in_data, in_valid, out_ready, n_f,
      input  in_ready, out_data, out_valid, n_x, n_w, n_b, n_enable
   );

endinterface

// File: rtl/neuron_4input_driver.sv
// Collects 9 serial words into neuron operands, fires once, returns f NEURON_LATENCY+1 cycles later.
// No overlap: in_ready is low from the last load handshake until the result is taken.
module neuron_4input_driver
   import neuron_4input_driver_pkg::*;
#(
   parameter int NEURON_LATENCY = 1,
   parameter int WORD_W         = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   neuron_4input_driver_if.master bus
);

   localparam int LAT_W = (NEURON_LATENCY > 1) ? $clog2(NEURON_LATENCY) : 1;

   state_t             state_q, state_d;
   logic [3:0]         wcnt_q, wcnt_d;
   logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
   logic [WORD_W-1:0]  out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic [WORD_W-1:0]  ops_q [NUM_WORDS];
   logic               in_hs;

   // in_ready is registered so it reads 0 during reset and rises on the first edge after release
   assign in_hs = in_ready_q && bus.in_valid;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      lat_cnt_d   = lat_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         ST_LOAD: begin
            if (in_hs) begin
               if (is_last_slot(wcnt_q)) begin
                  state_d = ST_FIRE;
                  wcnt_d  = 4'd0;
               end else begin
                  wcnt_d = wcnt_q + 4'd1;
               end
            end
         end
         ST_FIRE: begin
            state_d   = ST_WAIT;
            lat_cnt_d = '0;
         end
         ST_WAIT: begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
            if (lat_cnt_q == LAT_W'(NEURON_LATENCY - 1)) begin
               out_data_d  = bus.n_f;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
      in_ready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         wcnt_q      <= 4'd0;
         lat_cnt_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         lat_cnt_q   <= lat_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   // Operands only move on load handshakes, so n_b stays put while the neuron pipe drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) ops_q[i] <= '0;
      end else if (in_hs) begin
         ops_q[wcnt_q] <= bus.in_data;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.n_enable  = (state_q == ST_FIRE);
   assign bus.n_x = {ops_q[SLOT_X1+3], ops_q[SLOT_X1+2], ops_q[SLOT_X1+1], ops_q[SLOT_X1]};
   assign bus.n_w = {ops_q[SLOT_W1+3], ops_q[SLOT_W1+2], ops_q[SLOT_W1+1], ops_q[SLOT_W1]};
   assign bus.n_b = ops_q[SLOT_B];

endmodule

// File: tb/tb_neuron_4input_driver.sv
// Bench for neuron_4input_driver: a one-stage neuron stand-in plus a word-list reference model.
module tb_neuron_4input_driver;
   import neuron_4input_driver_pkg::*;

   localparam int LAT = 1;
   localparam int W   = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   neuron_4input_driver_if #(.WORD_W(W)) bus ();

   neuron_4input_driver #(.NEURON_LATENCY(LAT), .WORD_W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Neuron stand-in: products registered on enable, bias added after the register, then ReLU
   logic [W-1:0] pipe_q;
   function automatic logic [W-1:0] relu(input logic [W-1:0] v);
      return v[W-1] ? '0 : v;
   endfunction
   function automatic logic [W-1:0] dot4(input logic [4*W-1:0] x, input logic [4*W-1:0] w);
      logic [W-1:0] s;
      s = '0;
      for (int i = 0; i < 4; i++) s = s + x[i*W +: W] * w[i*W +: W];
      return s;
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            pipe_q <= '0;
      else if (bus.n_enable) pipe_q <= dot4(bus.n_x, bus.n_w);
   end
   assign bus.n_f = relu(pipe_q + bus.n_b);

   int n_chk  = 0;
   int n_pass = 0;
   function automatic void chk(input bit ok, input string name,
                               input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endfunction

   // Reference model: operand slots as seen by the neuron, expected results in order
   int           cyc = 0;
   logic [W-1:0] slot [NUM_WORDS];
   int           wcnt_m = 0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] got_q [$];
   int           hs_cyc = -100;
   bit           fire_pend = 1'b0;
   bit           prev_ov = 1'b0, prev_taken = 1'b0;
   logic [W-1:0] prev_od = '0;
   logic [W-1:0] last_out = '0;
   int           n_results = 0;
   bit           exp_en;
   logic [W-1:0] acc;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) slot[i] = '0;
         wcnt_m = 0;
         exp_q.delete();
         fire_pend = 1'b0;
         hs_cyc = -100;
         prev_ov = 1'b0;
         prev_taken = 1'b0;
         chk(!bus.in_ready && !bus.out_valid && !bus.n_enable, "reset_outputs",
             {bus.in_ready, bus.out_valid, bus.n_enable}, 0);
      end else begin
         chk(bus.n_x == {slot[3], slot[2], slot[1], slot[0]}, "n_x", bus.n_x,
             {slot[3], slot[2], slot[1], slot[0]});
         chk(bus.n_w == {slot[7], slot[6], slot[5], slot[4]}, "n_w", bus.n_w,
             {slot[7], slot[6], slot[5], slot[4]});
         chk(bus.n_b == slot[8], "n_b", bus.n_b, slot[8]);
         exp_en = fire_pend && (cyc == hs_cyc);
         chk(bus.n_enable == exp_en, "n_enable", bus.n_enable, exp_en);
         if (exp_en) fire_pend = 1'b0;
         if (bus.out_valid) chk(!bus.in_ready, "no_overlap_in_ready", bus.in_ready, 0);
         if (prev_ov && !prev_taken) begin
            chk(bus.out_valid, "hold_valid", bus.out_valid, 1);
            chk(bus.out_data == prev_od, "hold_data", bus.out_data, prev_od);
         end
         if (bus.out_valid && !prev_ov)
            chk(cyc == hs_cyc + LAT + 1, "latency", cyc - (hs_cyc - 1), LAT + 1);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_result", bus.out_data, 0);
            end else begin
               chk(bus.out_data == exp_q[0], "result", bus.out_data, exp_q[0]);
               void'(exp_q.pop_front());
            end
            last_out = bus.out_data;
            got_q.push_back(bus.out_data);
            n_results++;
         end
         if (bus.in_valid && bus.in_ready) begin
            slot[wcnt_m] = bus.in_data;
            wcnt_m++;
            if (wcnt_m == NUM_WORDS) begin
               acc = slot[8];
               for (int i = 0; i < 4; i++) acc = acc + slot[i] * slot[4+i];
               exp_q.push_back(acc[W-1] ? '0 : acc);
               wcnt_m = 0;
               hs_cyc = cyc + 1;
               fire_pend = 1'b1;
            end
         end
         prev_ov = bus.out_valid;
         prev_taken = bus.out_valid && bus.out_ready;
         prev_od = bus.out_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] d, input int gap);
      int t;
      t = 0;
      bus.in_valid = 1'b0;
      repeat (gap) step();
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) chk(1'b0, "in_ready_timeout", t, 100);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic run_op(input int wv [NUM_WORDS], input int gap);
      for (int i = 0; i < NUM_WORDS; i++)
         send_word(wv[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
   endtask

   task automatic wait_results(input int target);
      int t;
      t = 0;
      while (n_results < target && t < 300) begin
         step();
         t++;
      end
      chk(n_results >= target, "result_timeout", n_results, target);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int  wv [NUM_WORDS];
   int  base;
   int  n_rand;
   bit  rand_on;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk(bus.in_ready == 0 && bus.out_valid == 0 && bus.n_enable == 0, "reset_flags",
          {bus.in_ready, bus.out_valid, bus.n_enable}, 0);
      chk(bus.out_data == 0 && bus.n_b == 0, "reset_data", {bus.out_data, bus.n_b}, 0);
      chk(bus.n_x == 0 && bus.n_w == 0, "reset_operands", bus.n_x | bus.n_w, 0);
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk(bus.in_ready == 1, "ready_after_reset", bus.in_ready, 1);

      // Basic dot product
      wv = '{1, 2, 3, 4, 1, 1, 1, 1, 0};
      run_op(wv, 0);
      wait_results(1);
      chk(last_out == 10, "t1_result", last_out, 10);

      // ReLU at exactly zero and clipped negative
      wv = '{-5, 2, 0, 0, 1, 1, 0, 0, 3};
      run_op(wv, 0);
      wait_results(2);
      chk(last_out == 0, "t2a_zero", last_out, 0);
      wv = '{5, 0, 0, 0, -2, 0, 0, 0, 1};
      run_op(wv, 0);
      wait_results(3);
      chk(last_out == 0, "t2b_clip", last_out, 0);

      // Sink stalls in HOLD for 5 cycles
      bus.out_ready = 1'b0;
      wv = '{3, 0, 0, 0, 4, 0, 0, 0, 5};
      run_op(wv, 0);
      begin
         int t;
         t = 0;
         while (!bus.out_valid && t < 50) begin step(); t++; end
         chk(bus.out_valid == 1, "t3_valid_rise", bus.out_valid, 1);
      end
      repeat (5) step();
      chk(bus.out_valid == 1 && bus.out_data == 17, "t3_held", bus.out_data, 17);
      base = n_results;
      bus.out_ready = 1'b1;
      step();
      chk(bus.out_valid == 0, "t3_consume_first", bus.out_valid, 0);
      chk(n_results == base + 1, "t3_one_handshake", n_results, base + 1);

      // Gaps between words
      wv = '{1, 2, 3, 4, 1, 1, 1, 1, 0};
      run_op(wv, 3);
      wait_results(5);
      chk(last_out == 10, "t4_gaps", last_out, 10);

      // Reset during WAIT aborts the operation
      wv = '{7, 0, 0, 0, 7, 0, 0, 0, 0};
      run_op(wv, 0);
      step();
      rst_n = 1'b0;
      #1;
      chk(bus.out_valid == 0 && bus.in_ready == 0, "t5_reset_now",
          {bus.out_valid, bus.in_ready}, 0);
      chk(bus.n_b == 0 && bus.n_x == 0, "t5_operands_cleared", bus.n_x, 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk(bus.in_ready == 1, "t5_ready_again", bus.in_ready, 1);
      base = n_results;
      wv = '{1, 1, 1, 1, 2, 2, 2, 2, -3};
      run_op(wv, 0);
      wait_results(base + 1);
      chk(last_out == 5, "t5_fresh_result", last_out, 5);
      chk(n_results == base + 1, "t5_no_stale_result", n_results, base + 1);

      // Back-to-back operations, second source already waiting
      base = n_results;
      wv = '{2, 2, 2, 2, 1, 1, 1, 1, 1};
      run_op(wv, 0);
      wv = '{1, 0, 0, 0, 7, 0, 0, 0, 0};
      run_op(wv, 0);
      wait_results(base + 2);
      chk(got_q.size() == base + 2 && got_q[base] == 9, "t6_first", got_q[base], 9);
      chk(got_q.size() == base + 2 && got_q[base+1] == 7, "t6_second", got_q[base+1], 7);

      // Random operands, gaps and sink backpressure
      base = n_results;
      n_rand = 25;
      rand_on = 1'b1;
      fork
         begin
            for (int k = 0; k < n_rand; k++) begin
               for (int i = 0; i < NUM_WORDS; i++)
                  wv[i] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                      : int'($urandom_range(0, 20)) - 10;
               run_op(wv, -1);
            end
            wait_results(base + n_rand);
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               step();
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      repeat (3) step();
      chk(exp_q.size() == 0, "leftover_expected", exp_q.size(), 0);
      chk(n_results == base + n_rand, "random_count", n_results, base + n_rand);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
